// File: rtl/apb_fifo_pkg.sv
// Shared sizing helpers and error-flag record for the APB request/response FIFO.
package apb_fifo_pkg;

   function automatic int lvl_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_w(input int depth);
      return ($clog2(depth) < 1) ? 1 : $clog2(depth);
   endfunction

   typedef struct packed {
      logic ovf;
      logic udf;
   } fifo_err_t;

endpackage

// File: rtl/apb_fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: counts 0..DEPTH-1 and wraps explicitly, so DEPTH need not be a power of 2.
module apb_fifo_wrap_ptr
   import apb_fifo_pkg::*;
#(
   parameter int DEPTH = 8,
   localparam int PTR_W = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   logic [PTR_W-1:0] ptr_reg;
   logic [PTR_W-1:0] ptr_next;

   always_comb begin
      ptr_next = ptr_reg;
      if (inc) begin
         ptr_next = (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

   assign ptr = ptr_reg;

endmodule

// File: rtl/apb_param_fifo.sv
// Parametrised APB request/response FIFO: any depth >= 2, occupancy count, threshold flags,
// sticky error flags, FWFT or registered read, and a same-transaction flag on a data field.
module apb_param_fifo
   import apb_fifo_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 8,
   parameter int AF_LVL  = DEPTH - 1,
   parameter int AE_LVL  = 1,
   parameter bit FWFT    = 1'b1,
   parameter int CMP_MSB = DATA_W - 1,
   parameter int CMP_LSB = 0,
   localparam int LVL_W  = lvl_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              empty,
   output logic              full,
   output logic              almost_empty,
   output logic              almost_full,
   output logic [LVL_W-1:0]  level,
   output logic              ovf,
   output logic              udf,
   input  logic              clr_err,
   output logic              trnscn_cont
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   if (DEPTH < 2) begin : g_bad_depth
      $error("apb_param_fifo: DEPTH must be >= 2");
   end
   if (AF_LVL < 1 || AF_LVL > DEPTH) begin : g_bad_af
      $error("apb_param_fifo: AF_LVL must be in 1..DEPTH");
   end
   if (AE_LVL < 0 || AE_LVL > DEPTH - 1) begin : g_bad_ae
      $error("apb_param_fifo: AE_LVL must be in 0..DEPTH-1");
   end
   if (CMP_LSB < 0 || CMP_LSB > CMP_MSB || CMP_MSB >= DATA_W) begin : g_bad_cmp
      $error("apb_param_fifo: compare field must satisfy 0 <= CMP_LSB <= CMP_MSB < DATA_W");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  rd_ptr_nxt;
   logic [LVL_W-1:0]  level_reg;
   logic [LVL_W-1:0]  level_next;
   logic              rd_acc;
   logic              wr_acc;
   fifo_err_t         err_reg;
   fifo_err_t         err_next;

   // No read bypass: a read is only accepted against an entry already stored.
   always_comb begin
      rd_acc       = rd_en && (level_reg != '0);
      wr_acc       = wr_en && ((level_reg != LVL_FULL) || rd_acc);
      level_next   = level_reg + LVL_W'(wr_acc) - LVL_W'(rd_acc);
      err_next.ovf = (wr_en && !wr_acc) || (err_reg.ovf && !clr_err);
      err_next.udf = (rd_en && (level_reg == '0)) || (err_reg.udf && !clr_err);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_reg <= '0;
         err_reg   <= '0;
      end else begin
         level_reg <= level_next;
         err_reg   <= err_next;
      end
   end

   apb_fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (wr_acc),
      .ptr   (wr_ptr)
   );

   apb_fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (rd_acc),
      .ptr   (rd_ptr)
   );

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   assign rd_ptr_nxt   = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
   // Gating on level keeps unwritten (unreset) entries out of the compare.
   assign trnscn_cont  = (level_reg >= LVL_W'(2)) &&
                         (mem[rd_ptr][CMP_MSB:CMP_LSB] == mem[rd_ptr_nxt][CMP_MSB:CMP_LSB]);

   assign empty        = (level_reg == '0);
   assign full         = (level_reg == LVL_FULL);
   assign almost_empty = (level_reg <= LVL_W'(AE_LVL));
   assign almost_full  = (level_reg >= LVL_W'(AF_LVL));
   assign level        = level_reg;
   assign ovf          = err_reg.ovf;
   assign udf          = err_reg.udf;

   if (FWFT) begin : g_fwft
      // Head is shown only while it holds live data; zero otherwise.
      assign rd_data  = (level_reg == '0) ? '0 : mem[rd_ptr];
      assign rd_valid = (level_reg != '0);
   end else begin : g_reg_read
      logic [DATA_W-1:0] rd_data_reg;
      logic              rd_valid_reg;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
         end else begin
            rd_valid_reg <= rd_acc;
            if (rd_acc) begin
               rd_data_reg <= mem[rd_ptr];
            end
         end
      end

      assign rd_data  = rd_data_reg;
      assign rd_valid = rd_valid_reg;
   end

endmodule
